// File: rtl/mips_pkg.sv
// Shared constants and types for the mips fetch front end.
// The prefetch FSM state type and the reset fetch address live here.
package mips_pkg;

    localparam logic [31:0] PC_INIT_DEFAULT = 32'h8002_0000;

    typedef enum logic {RUN, DRAIN} pf_state_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush and an occupancy count.
// The head output is forced to zero when the FIFO is empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    input  logic                       i_flush,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_valid,
    output logic [WIDTH-1:0]           o_head
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;

    logic w_do_pop;
    logic w_do_push;

    assign w_do_pop  = i_pop && (r_count != '0);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_do_push = i_push && ((r_count != CW'(DEPTH)) || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    assign o_count = r_count;
    assign o_valid = (r_count != '0);
    assign o_head  = o_valid ? r_mem[r_rptr] : '0;

endmodule

// File: rtl/instr_prefetch_buffer.sv
// Sequential instruction prefetcher feeding the mips fetch stage.
// Issues in-order word reads, buffers returned words, and discards responses made stale by redirects.
module instr_prefetch_buffer
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter logic [31:0] PC_INIT = PC_INIT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    pf_state_t   r_state;
    logic [31:0] r_fetch_pc;
    logic [31:0] r_ret_pc;
    logic [CW-1:0] r_live;
    logic [CW-1:0] r_drop;

    logic [CW-1:0] w_count;
    logic [CW:0]   w_inflight;
    logic          w_credit_ok;
    logic          w_grant;
    logic          w_drop_rsp;
    logic          w_keep_rsp;
    logic          w_any_rsp;
    logic          w_push;
    logic [CW-1:0] w_drop_after;
    logic [63:0]   w_head;

    assign w_inflight  = {1'b0, w_count} + {1'b0, r_live};
    assign w_credit_ok = w_inflight < (CW + 1)'(DEPTH);

    assign mem_req  = !reset && (r_state == RUN) && w_credit_ok && !redirect;
    assign mem_addr = r_fetch_pc;
    assign w_grant  = mem_req && mem_gnt;

    // Stale responses are consumed first; a response with nothing outstanding is ignored.
    assign w_drop_rsp   = mem_rvalid && (r_drop != '0);
    assign w_keep_rsp   = mem_rvalid && (r_drop == '0) && (r_live != '0);
    assign w_any_rsp    = w_drop_rsp || w_keep_rsp;
    assign w_push       = w_keep_rsp && !redirect;
    assign w_drop_after = r_drop + r_live - CW'(w_any_rsp);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= RUN;
            r_fetch_pc <= PC_INIT;
            r_ret_pc   <= PC_INIT;
            r_live     <= '0;
            r_drop     <= '0;
        end else if (redirect) begin
            r_fetch_pc <= word_align(redirect_pc);
            r_ret_pc   <= word_align(redirect_pc);
            r_live     <= '0;
            r_drop     <= w_drop_after;
            r_state    <= (w_drop_after == '0) ? RUN : DRAIN;
        end else begin
            if (w_grant) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            if (w_keep_rsp) begin
                r_ret_pc <= r_ret_pc + 32'd4;
            end
            r_live <= r_live + CW'(w_grant) - CW'(w_keep_rsp);
            if (w_drop_rsp) begin
                r_drop <= r_drop - CW'(1);
            end
            // Leave DRAIN as the last stale response retires so fetch restarts next cycle.
            if ((r_state == DRAIN) &&
                ((r_drop == '0) || (w_drop_rsp && (r_drop == CW'(1))))) begin
                r_state <= RUN;
            end
        end
    end

    sync_fifo #(
        .WIDTH (64),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  ({r_ret_pc, mem_rdata}),
        .i_pop   (out_ready),
        .i_flush (redirect),
        .o_count (w_count),
        .o_valid (out_valid),
        .o_head  (w_head)
    );

    assign out_pc    = w_head[63:32];
    assign out_instr = w_head[31:0];

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Self-checking bench for instr_prefetch_buffer: directed vector table, redirect/wrap sequences,
// and a randomised run against an in-order memory model with an epoch-tagged scoreboard.
module tb_instr_prefetch_buffer;

    localparam int unsigned DEPTH   = 4;
    localparam logic [31:0] PC_INIT = 32'h8002_0000;

    logic        clk;
    logic        reset;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    instr_prefetch_buffer #(
        .DEPTH   (DEPTH),
        .PC_INIT (PC_INIT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          ep;
    } rsp_t;

    typedef struct {
        logic        rdy;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_ov;
        logic [31:0] exp_pc;
    } vec_t;

    rsp_t        q[$];
    int          cyc;
    int          lat;
    int          last_due;
    int          epoch;
    int          b_cnt;
    logic [31:0] f_pc;
    logic [31:0] exp_pc;
    int          n_checks;
    int          n_fail;

    logic        s_req;
    logic [31:0] s_addr;
    logic        s_ov;
    logic [31:0] s_pc;
    logic [31:0] s_instr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, req);
        end
    endtask

    // Drives one cycle's inputs, checks outputs against the model, then advances past the edge.
    task automatic cycle(input logic rd, input logic [31:0] rpc, input logic rdy, input logic g);
        int   n_old;
        int   n_live;
        int   due;
        rsp_t r;
        logic rv_cur;
        redirect    = rd;
        redirect_pc = rpc;
        out_ready   = rdy;
        mem_gnt     = g;
        n_old  = 0;
        n_live = 0;
        foreach (q[i]) begin
            if (q[i].ep == epoch) n_live++;
            else n_old++;
        end
        rv_cur = 1'b0;
        if (q.size() > 0 && q[0].due == cyc) begin
            r          = q.pop_front();
            mem_rvalid = 1'b1;
            mem_rdata  = mem_word(r.addr);
            rv_cur     = 1'b1;
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = 32'hDEAD_BEEF;
        end
        #2;
        s_req   = mem_req;
        s_addr  = mem_addr;
        s_ov    = out_valid;
        s_pc    = out_pc;
        s_instr = out_instr;
        chk("mem_req", 32'(mem_req), 32'(!rd && n_old == 0 && (b_cnt + n_live < DEPTH)));
        if (mem_req) chk("mem_addr", mem_addr, f_pc);
        chk("out_valid", 32'(out_valid), 32'(b_cnt > 0));
        if (b_cnt > 0) begin
            chk("out_pc", out_pc, exp_pc);
            chk("out_instr", out_instr, mem_word(exp_pc));
        end else begin
            chk("idle_pc", out_pc, 32'h0);
            chk("idle_instr", out_instr, 32'h0);
        end
        if (b_cnt > 0 && rdy) begin
            b_cnt--;
            exp_pc = exp_pc + 32'd4;
        end
        if (mem_req && g) begin
            due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
            last_due = due;
            q.push_back('{addr: f_pc, due: due, ep: epoch});
            f_pc = f_pc + 32'd4;
        end
        if (rd) begin
            epoch++;
            b_cnt  = 0;
            f_pc   = {rpc[31:2], 2'b00};
            exp_pc = {rpc[31:2], 2'b00};
        end else if (rv_cur && r.ep == epoch) begin
            b_cnt++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        out_ready   = 1'b0;
        mem_gnt     = 1'b0;
        mem_rvalid  = 1'b0;
        mem_rdata   = 32'h0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_instr", out_instr, 32'h0);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_mem_req", 32'(mem_req), 32'h0);
        chk("rst_mem_addr", mem_addr, PC_INIT);
        q.delete();
        f_pc     = PC_INIT;
        exp_pc   = PC_INIT;
        b_cnt    = 0;
        epoch    = 0;
        last_due = -1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc   = 0;
    endtask

    task automatic wait_valid(input string name, input logic rdy, output logic found);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            cycle(1'b0, 32'h0, rdy, 1'b1);
            found = s_ov;
        end
        chk(name, 32'(found), 32'h1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t vecs[15];
        logic found;
        logic rd;
        logic [31:0] rpc;
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        lat      = 1;

        // Stall from reset with 1-cycle memory: four grants, then drain and resume at +0x10.
        vecs[0]  = '{1'b0, 1'b1, 32'h8002_0000, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 1'b1, 32'h8002_0004, 1'b0, 32'h0};
        vecs[2]  = '{1'b0, 1'b1, 32'h8002_0008, 1'b1, 32'h8002_0000};
        vecs[3]  = '{1'b0, 1'b1, 32'h8002_000C, 1'b1, 32'h8002_0000};
        vecs[4]  = '{1'b0, 1'b0, 32'h8002_0010, 1'b1, 32'h8002_0000};
        vecs[5]  = '{1'b0, 1'b0, 32'h8002_0010, 1'b1, 32'h8002_0000};
        vecs[6]  = '{1'b0, 1'b0, 32'h8002_0010, 1'b1, 32'h8002_0000};
        vecs[7]  = '{1'b1, 1'b0, 32'h8002_0010, 1'b1, 32'h8002_0000};
        vecs[8]  = '{1'b1, 1'b1, 32'h8002_0010, 1'b1, 32'h8002_0004};
        vecs[9]  = '{1'b1, 1'b1, 32'h8002_0014, 1'b1, 32'h8002_0008};
        vecs[10] = '{1'b1, 1'b1, 32'h8002_0018, 1'b1, 32'h8002_000C};
        vecs[11] = '{1'b1, 1'b1, 32'h8002_001C, 1'b1, 32'h8002_0010};
        vecs[12] = '{1'b1, 1'b1, 32'h8002_0020, 1'b1, 32'h8002_0014};
        vecs[13] = '{1'b1, 1'b1, 32'h8002_0024, 1'b1, 32'h8002_0018};
        vecs[14] = '{1'b1, 1'b1, 32'h8002_0028, 1'b1, 32'h8002_001C};

        do_reset();
        lat = 1;
        for (int i = 0; i < 15; i++) begin
            cycle(1'b0, 32'h0, vecs[i].rdy, 1'b1);
            chk("tbl_req", 32'(s_req), 32'(vecs[i].exp_req));
            chk("tbl_addr", s_addr, vecs[i].exp_addr);
            chk("tbl_ov", 32'(s_ov), 32'(vecs[i].exp_ov));
            chk("tbl_pc", s_pc, vecs[i].exp_pc);
            chk("tbl_instr", s_instr, vecs[i].exp_ov ? mem_word(vecs[i].exp_pc) : 32'h0);
        end

        // Redirect with two reads in flight on a 3-cycle memory.
        do_reset();
        lat = 3;
        cycle(1'b0, 32'h0, 1'b1, 1'b1);
        cycle(1'b0, 32'h0, 1'b1, 1'b1);
        cycle(1'b1, 32'h8003_0003, 1'b1, 1'b1);
        chk("redir_req", 32'(s_req), 32'h0);
        cycle(1'b0, 32'h0, 1'b1, 1'b1);
        chk("drain1_req", 32'(s_req), 32'h0);
        chk("drain1_ov", 32'(s_ov), 32'h0);
        cycle(1'b0, 32'h0, 1'b1, 1'b1);
        chk("drain2_req", 32'(s_req), 32'h0);
        chk("drain2_ov", 32'(s_ov), 32'h0);
        cycle(1'b0, 32'h0, 1'b1, 1'b1);
        chk("resume_req", 32'(s_req), 32'h1);
        chk("resume_addr", s_addr, 32'h8003_0000);
        wait_valid("drain_first_valid", 1'b1, found);
        chk("drain_first_pc", s_pc, 32'h8003_0000);

        // Redirect coincident with a response while the credit is fully used.
        do_reset();
        lat = 1;
        repeat (4) cycle(1'b0, 32'h0, 1'b0, 1'b1);
        cycle(1'b1, 32'h8004_0000, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 1'b1, 1'b1);
        chk("coinc_ov", 32'(s_ov), 32'h0);
        chk("coinc_req", 32'(s_req), 32'h1);
        chk("coinc_addr", s_addr, 32'h8004_0000);
        wait_valid("coinc_first_valid", 1'b1, found);
        chk("coinc_first_pc", s_pc, 32'h8004_0000);
        repeat (6) cycle(1'b0, 32'h0, 1'b1, 1'b1);

        // Address wrap at the top of the address space.
        cycle(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1);
        repeat (3) cycle(1'b0, 32'h0, 1'b1, 1'b1);
        cycle(1'b1, 32'hFFFF_FFFE, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 1'b1, 1'b1);
        chk("wrap_addr0", s_addr, 32'hFFFF_FFFC);
        cycle(1'b0, 32'h0, 1'b1, 1'b1);
        chk("wrap_addr1", s_addr, 32'h0000_0000);
        wait_valid("wrap_valid", 1'b1, found);
        chk("wrap_pc0", s_pc, 32'hFFFF_FFFC);
        cycle(1'b0, 32'h0, 1'b1, 1'b1);
        chk("wrap_ov1", 32'(s_ov), 32'h1);
        chk("wrap_pc1", s_pc, 32'h0000_0000);

        // Random gnt, latency, ready and redirects, with one reset mid-run.
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) do_reset();
            lat = $urandom_range(1, 5);
            rd  = ($urandom_range(0, 39) == 0);
            rpc = $urandom;
            if (i % 200 == 100) rpc = 32'hFFFF_FFF1;
            cycle(rd, rpc, ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
